// File: rtl/lvds_video_rx.sv
// 7:1 LVDS video receiver: aligns to the forwarded clock-lane pattern, tracks lock,
// and unpacks each 28-bit word from four data lanes into RGB888 + HS/VS/DE.
module lvds_video_rx #(
    parameter logic [6:0] CLK_PATTERN = 7'b1100011,
    parameter int         LOCK_COUNT  = 4,
    parameter int         ERR_LIMIT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ser_in,
    input  logic       clk_lane,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       data_enable,
    output logic       pixel_valid,
    output logic       locked,
    output logic       de_err,
    output logic       lock_lost
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [4:0] LOCK_N = 5'(LOCK_COUNT);
    localparam logic [4:0] ERR_N  = 5'(ERR_LIMIT);

    logic [6:0] sr_0;
    logic [6:0] sr_1;
    logic [6:0] sr_2;
    logic [6:0] sr_3;
    logic [6:0] csr;
    logic [2:0] phase;
    logic [1:0] state;
    logic [3:0] good_cnt;
    logic [3:0] err_cnt;

    logic       bnd;
    logic       pat_ok;
    logic [4:0] good_inc;
    logic [4:0] err_inc;

    // Counters are widened by one bit so the threshold compare cannot wrap at 15.
    always_comb begin
        bnd      = (phase == 3'd0);
        pat_ok   = (csr == CLK_PATTERN);
        good_inc = {1'b0, good_cnt} + 5'd1;
        err_inc  = {1'b0, err_cnt} + 5'd1;
    end

    // pixel_valid, de_err and lock_lost are single-cycle strobes with no back-pressure:
    // the pixel fields are meaningful on the cycle pixel_valid is high and simply hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_0        <= '0;
            sr_1        <= '0;
            sr_2        <= '0;
            sr_3        <= '0;
            csr         <= '0;
            phase       <= '0;
            state       <= ST_HUNT;
            good_cnt    <= '0;
            err_cnt     <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            data_enable <= 1'b0;
            pixel_valid <= 1'b0;
            locked      <= 1'b0;
            de_err      <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            sr_0 <= {sr_0[5:0], ser_in[0]};
            sr_1 <= {sr_1[5:0], ser_in[1]};
            sr_2 <= {sr_2[5:0], ser_in[2]};
            sr_3 <= {sr_3[5:0], ser_in[3]};
            csr  <= {csr[5:0], clk_lane};

            pixel_valid <= 1'b0;
            de_err      <= 1'b0;
            lock_lost   <= 1'b0;
            phase       <= (phase == 3'd6) ? 3'd0 : phase + 3'd1;

            case (state)
                ST_HUNT: begin
                    // A match here means the word just completed; the next one completes 7 clks on.
                    if (pat_ok) begin
                        phase    <= 3'd1;
                        good_cnt <= 4'd1;
                        if (LOCK_N == 5'd1) begin
                            state   <= ST_LOCKED;
                            locked  <= 1'b1;
                            err_cnt <= '0;
                        end else begin
                            state <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    if (bnd) begin
                        if (pat_ok) begin
                            good_cnt <= good_inc[3:0];
                            if (good_inc >= LOCK_N) begin
                                state   <= ST_LOCKED;
                                locked  <= 1'b1;
                                err_cnt <= '0;
                            end
                        end else begin
                            state    <= ST_HUNT;
                            good_cnt <= '0;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (bnd) begin
                        if (!pat_ok && (err_inc >= ERR_N)) begin
                            state     <= ST_HUNT;
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                            err_cnt   <= '0;
                            good_cnt  <= '0;
                        end else begin
                            err_cnt     <= pat_ok ? 4'd0 : err_inc[3:0];
                            // Bit 6 of each lane register is the first bit on the wire.
                            red         <= {sr_3[5], sr_3[6], sr_0[1], sr_0[2],
                                            sr_0[3], sr_0[4], sr_0[5], sr_0[6]};
                            green       <= {sr_3[3], sr_3[4], sr_1[2], sr_1[3],
                                            sr_1[4], sr_1[5], sr_1[6], sr_0[0]};
                            blue        <= {sr_3[1], sr_3[2], sr_2[3], sr_2[4],
                                            sr_2[5], sr_2[6], sr_1[0], sr_1[1]};
                            hsync       <= sr_2[2];
                            vsync       <= sr_2[1];
                            data_enable <= sr_2[0];
                            de_err      <= sr_2[0] ^ sr_3[0];
                            pixel_valid <= 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= ST_HUNT;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                    err_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_video_rx.sv
// Directed bench for lvds_video_rx: serialises pixel records onto the lanes and scores
// every emitted pixel against an expected queue keyed by the cycle it is due.
module tb_lvds_video_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ser_in;
    logic       clk_lane;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       hsync;
    logic       vsync;
    logic       data_enable;
    logic       pixel_valid;
    logic       locked;
    logic       de_err;
    logic       lock_lost;

    lvds_video_rx dut (
        .clk         (clk),
        .rst         (rst),
        .ser_in      (ser_in),
        .clk_lane    (clk_lane),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync       (hsync),
        .vsync       (vsync),
        .data_enable (data_enable),
        .pixel_valid (pixel_valid),
        .locked      (locked),
        .de_err      (de_err),
        .lock_lost   (lock_lost)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [6:0] GOOD_CK = 7'b1100011;
    localparam logic [6:0] BAD_CK  = 7'b1010101;
    localparam int         NV      = 27;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       de3;
        logic       de4;
        logic [7:0] exp_r;
        logic [7:0] exp_g;
        logic [7:0] exp_b;
        logic       exp_hs;
        logic       exp_vs;
        logic       exp_de;
        logic       exp_err;
    } vec_t;

    vec_t vecs[NV];

    // ---------------- scoreboard ----------------
    logic [27:0] exp_q[$];
    int          due_q[$];
    int          checks = 0;
    int          fails = 0;
    int          lost_cnt = 0;
    int          lost_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [27:0] got;
        got = {red, green, blue, hsync, vsync, data_enable, de_err};
        if (pixel_valid === 1'b1) begin
            checks++;
            if (due_q.size() == 0 || due_q[0] != cyc) begin
                fails++;
                $display("FAIL unexpected_pixel: got %h expected no pixel (cyc %0d)", got, cyc);
            end else begin
                if (got !== exp_q[0]) begin
                    fails++;
                    $display("FAIL pixel: got %h expected %h (cyc %0d)", got, exp_q[0], cyc);
                end
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end else if (due_q.size() > 0 && due_q[0] == cyc) begin
            checks++;
            fails++;
            $display("FAIL missing_pixel: got none expected %h (cyc %0d)", exp_q[0], cyc);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
        if (de_err === 1'b1 && pixel_valid !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL stray_de_err: got 1 expected 0 without pixel_valid (cyc %0d)", cyc);
        end
        if (lock_lost === 1'b1) begin
            lost_cnt++;
            lost_cyc = cyc;
        end
    end

    // ---------------- driver ----------------
    function automatic vec_t mk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                input logic hs, input logic vs, input logic de3, input logic de4,
                                input logic exp_de, input logic exp_err);
        vec_t v;
        v.r = r; v.g = g; v.b = b; v.hs = hs; v.vs = vs; v.de3 = de3; v.de4 = de4;
        v.exp_r = r; v.exp_g = g; v.exp_b = b; v.exp_hs = hs; v.exp_vs = vs;
        v.exp_de = exp_de; v.exp_err = exp_err;
        return v;
    endfunction

    // Lane words {lane3, lane2, lane1, lane0}, bit 6 of each sent first.
    function automatic logic [27:0] encode(input vec_t v);
        logic [6:0] l3, l2, l1, l0;
        l3 = {v.r[6], v.r[7], v.g[6], v.g[7], v.b[6], v.b[7], v.de4};
        l2 = {v.b[2], v.b[3], v.b[4], v.b[5], v.hs, v.vs, v.de3};
        l1 = {v.g[1], v.g[2], v.g[3], v.g[4], v.g[5], v.b[0], v.b[1]};
        l0 = {v.r[0], v.r[1], v.r[2], v.r[3], v.r[4], v.r[5], v.g[0]};
        return {l3, l2, l1, l0};
    endfunction

    // Returns on the negedge where the last bit is driven; its pixel is due two edges later.
    task automatic send_vec(input vec_t v, input logic [6:0] ck, input bit expect_pix);
        logic [27:0] w;
        w = encode(v);
        for (int i = 6; i >= 0; i--) begin
            @(negedge clk);
            ser_in   = {w[21+i], w[14+i], w[7+i], w[i]};
            clk_lane = ck[i];
        end
        if (expect_pix) begin
            exp_q.push_back({v.exp_r, v.exp_g, v.exp_b, v.exp_hs, v.exp_vs, v.exp_de, v.exp_err});
            due_q.push_back(cyc + 2);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({red, green, blue, hsync, vsync, data_enable,
                         pixel_valid, locked, de_err, lock_lost}), 32'd0);
    endtask

    // Four clean words to lock, then a fifth that must come out as a pixel.
    task automatic relock(input string name);
        for (int k = 0; k < 4; k++) send_vec(vecs[0], GOOD_CK, 1'b0);
        check({name, "_not_early"}, 32'(locked), 32'd0);
        send_vec(vecs[0], GOOD_CK, 1'b1);
        check({name, "_locked"}, 32'(locked), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int due2;
        logic [27:0] w;

        vecs[0] = mk(8'hA5, 8'h3C, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[1] = mk(8'h12, 8'h34, 8'h56, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[2] = mk(8'hFF, 8'h00, 8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            vecs[3+i] = mk((i < 8) ? 8'(1 << i) : 8'h00,
                           (i >= 8 && i < 16) ? 8'(1 << (i - 8)) : 8'h00,
                           (i >= 16) ? 8'(1 << (i - 16)) : 8'h00,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        rst      = 1'b1;
        ser_in   = '0;
        clk_lane = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;

        // Clean stream from reset.
        relock("clean_lock");
        for (int k = 0; k < 3; k++) send_vec(vecs[0], GOOD_CK, 1'b1);

        // Isolated clock-lane errors keep lock and the error count clears.
        send_vec(vecs[0], BAD_CK, 1'b1);
        send_vec(vecs[0], GOOD_CK, 1'b1);
        send_vec(vecs[0], BAD_CK, 1'b1);
        send_vec(vecs[0], GOOD_CK, 1'b1);
        check("lock_kept_single_err", 32'(locked), 32'd1);

        // Two consecutive bad words drop lock without a pixel for the second.
        send_vec(vecs[0], BAD_CK, 1'b1);
        send_vec(vecs[0], BAD_CK, 1'b0);
        due2 = cyc + 2;
        send_vec(vecs[0], GOOD_CK, 1'b0);
        check("lock_lost_count", 32'(lost_cnt), 32'd1);
        check("lock_lost_cycle", 32'(lost_cyc), 32'(due2));
        check("unlocked_after_loss", 32'(locked), 32'd0);
        for (int k = 0; k < 3; k++) send_vec(vecs[0], GOOD_CK, 1'b0);
        check("relock_not_early", 32'(locked), 32'd0);
        send_vec(vecs[0], GOOD_CK, 1'b1);
        check("relock_locked", 32'(locked), 32'd1);

        // Table: DE mismatch records and walking-one colour bits.
        for (int i = 1; i < NV; i++) send_vec(vecs[i], GOOD_CK, 1'b1);
        send_vec(vecs[0], GOOD_CK, 1'b1);

        // Reset three bits into a word while locked.
        w = encode(vecs[0]);
        for (int i = 6; i >= 4; i--) begin
            @(negedge clk);
            ser_in   = {w[21+i], w[14+i], w[7+i], w[i]};
            clk_lane = GOOD_CK[i];
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_mid_word");
        rst = 1'b0;
        relock("post_reset");
        send_vec(vecs[1], GOOD_CK, 1'b1);

        // Misaligned start: three junk bits ahead of the first word.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ser_in   = 4'b1010;
            clk_lane = (i != 1);
        end
        relock("junk_start");
        send_vec(vecs[2], GOOD_CK, 1'b1);
        send_vec(vecs[0], GOOD_CK, 1'b1);

        repeat (4) @(negedge clk);
        check("pending_pixels", 32'(exp_q.size()), 32'd0);
        check("total_lock_lost", 32'(lost_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
